// File: rtl/dram_responder.sv
// Single-bank DRAM-style command responder: decodes PRE/ACT/RD/WR strobes
// against one open row, serves reads through a fixed CAS-latency pipeline
// and commits byte-masked writes one cycle after the WR command.
module dram_responder #(
    parameter int ROW_BITS = 11,
    parameter int COL_BITS = 10,
    parameter int CAS_LAT  = 5,
    parameter int T_RP     = 1
) (
    input  logic        ACLK,
    input  logic        rst,
    input  logic        CSn,
    input  logic        RASn,
    input  logic        CASn,
    input  logic [3:0]  WEn,
    input  logic [10:0] A,
    input  logic [31:0] D,
    output logic [31:0] Q,
    output logic        VALID,
    output logic        ERR
);

    localparam int AW    = ROW_BITS + COL_BITS;
    localparam int DEPTH = 1 << AW;
    // Down-counter only has to hold T_RP-1; keep at least one bit.
    localparam int TRP_W = (T_RP > 1) ? $clog2(T_RP) : 1;

    logic [31:0]         mem_q [DEPTH];

    logic [ROW_BITS-1:0] row_reg_q, row_reg_d;
    logic                row_valid_q, row_valid_d;
    logic [TRP_W-1:0]    trp_cnt_q, trp_cnt_d;
    logic                wr_pend_q, wr_pend_d;
    logic [AW-1:0]       wr_addr_q, wr_addr_d;
    logic [3:0]          wr_wen_q, wr_wen_d;
    logic                err_q, err_d;

    logic [CAS_LAT-1:0]  rd_vld_q;
    logic [31:0]         rd_dat_q [CAS_LAT];

    logic                cmd_rd;
    logic [AW-1:0]       cas_addr;
    logic [31:0]         rd_word;

    assign cas_addr = {row_reg_q, A[COL_BITS-1:0]};
    // Combinational array read: a RD on the same edge as a write commit
    // therefore captures the pre-commit word.
    assign rd_word  = mem_q[cas_addr];

    // Command decode and next-state for row, tRP timer, write phase and ERR.
    always_comb begin
        row_reg_d   = row_reg_q;
        row_valid_d = row_valid_q;
        trp_cnt_d   = (trp_cnt_q != '0) ? trp_cnt_q - 1'b1 : trp_cnt_q;
        wr_pend_d   = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_wen_d    = wr_wen_q;
        err_d       = 1'b0;
        cmd_rd      = 1'b0;
        if (!CSn) begin
            if (!RASn && !CASn) begin
                err_d = 1'b1;
            end else if (!RASn) begin
                if (WEn == 4'h0) begin
                    trp_cnt_d = TRP_W'(T_RP - 1);
                end else if (WEn == 4'hF) begin
                    if (trp_cnt_q != '0) begin
                        err_d = 1'b1;
                    end else begin
                        row_reg_d   = A[ROW_BITS-1:0];
                        row_valid_d = 1'b1;
                    end
                end else begin
                    err_d = 1'b1;
                end
            end else if (!CASn) begin
                if (!row_valid_q) begin
                    err_d = 1'b1;
                end else if (WEn == 4'hF) begin
                    cmd_rd = 1'b1;
                end else begin
                    // Row is captured here too, so an ACT in the data-phase
                    // cycle cannot redirect the pending commit.
                    wr_pend_d = 1'b1;
                    wr_addr_d = cas_addr;
                    wr_wen_d  = WEn;
                end
            end
        end
    end

    // Control state registers.
    always_ff @(posedge ACLK or posedge rst) begin
        if (rst) begin
            row_reg_q   <= '0;
            row_valid_q <= 1'b0;
            trp_cnt_q   <= '0;
            wr_pend_q   <= 1'b0;
            wr_addr_q   <= '0;
            wr_wen_q    <= 4'hF;
            err_q       <= 1'b0;
        end else begin
            row_reg_q   <= row_reg_d;
            row_valid_q <= row_valid_d;
            trp_cnt_q   <= trp_cnt_d;
            wr_pend_q   <= wr_pend_d;
            wr_addr_q   <= wr_addr_d;
            wr_wen_q    <= wr_wen_d;
            err_q       <= err_d;
        end
    end

    // Write data phase: commit enabled bytes of D regardless of this cycle's command.
    always_ff @(posedge ACLK) begin
        if (wr_pend_q) begin
            for (int b = 0; b < 4; b++) begin
                if (!wr_wen_q[b]) begin
                    mem_q[wr_addr_q][8*b +: 8] <= D[8*b +: 8];
                end
            end
        end
    end

    // CAS-latency read pipeline; the last stage is the Q/VALID output, and
    // data stages only advance with a valid token so Q holds between reads.
    always_ff @(posedge ACLK or posedge rst) begin
        if (rst) begin
            rd_vld_q <= '0;
            for (int k = 0; k < CAS_LAT; k++) begin
                rd_dat_q[k] <= '0;
            end
        end else begin
            rd_vld_q[0] <= cmd_rd;
            if (cmd_rd) begin
                rd_dat_q[0] <= rd_word;
            end
            for (int k = 1; k < CAS_LAT; k++) begin
                rd_vld_q[k] <= rd_vld_q[k-1];
                if (rd_vld_q[k-1]) begin
                    rd_dat_q[k] <= rd_dat_q[k-1];
                end
            end
        end
    end

    assign Q     = rd_dat_q[CAS_LAT-1];
    assign VALID = rd_vld_q[CAS_LAT-1];
    assign ERR   = err_q;

endmodule

// File: tb/tb_dram_responder.sv
// Scoreboard bench for dram_responder: the driver runs a word/byte-level
// reference model and queues expected reads and error cycles; a negedge
// monitor checks VALID/Q/ERR against those expectations.
module tb_dram_responder;

    localparam int ROW_BITS = 8;
    localparam int COL_BITS = 6;
    localparam int CAS_LAT  = 5;
    localparam int T_RP     = 2;

    logic        ACLK = 1'b0;
    logic        rst  = 1'b1;
    logic        CSn  = 1'b1;
    logic        RASn = 1'b1;
    logic        CASn = 1'b1;
    logic [3:0]  WEn  = 4'hF;
    logic [10:0] A    = '0;
    logic [31:0] D    = '0;
    logic [31:0] Q;
    logic        VALID;
    logic        ERR;

    dram_responder #(
        .ROW_BITS(ROW_BITS),
        .COL_BITS(COL_BITS),
        .CAS_LAT (CAS_LAT),
        .T_RP    (T_RP)
    ) dut (
        .ACLK (ACLK),
        .rst  (rst),
        .CSn  (CSn),
        .RASn (RASn),
        .CASn (CASn),
        .WEn  (WEn),
        .A    (A),
        .D    (D),
        .Q    (Q),
        .VALID(VALID),
        .ERR  (ERR)
    );

    always #5 ACLK = ~ACLK;

    int edge_cnt = 0;
    always @(posedge ACLK) edge_cnt <= edge_cnt + 1;

    typedef struct {
        logic [31:0] data;
        bit          known;
        int          due;
    } rd_t;

    rd_t         exp_q[$];
    bit          exp_err[int];
    logic [31:0] ref_mem[int];
    logic [3:0]  ref_bytes[int];

    int n_cmp  = 0;
    int n_fail = 0;

    bit          m_row_valid = 0;
    int          m_row       = 0;
    int          m_last_pre  = -100;
    bit          m_pend      = 0;
    int          m_pend_key  = 0;
    logic [3:0]  m_pend_wen  = 4'hF;
    logic [31:0] last_q      = '0;
    bit          last_known  = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %h, expected %h", name, edge_cnt, act, exp);
        end
    endtask

    // Drive one command for the next rising edge k and advance the model.
    task automatic issue(input logic cs, input logic ras, input logic cas,
                         input logic [3:0] wen, input logic [10:0] a, input logic [31:0] d);
        int          k;
        int          key;
        bit          err;
        rd_t         e;
        logic [31:0] w;
        logic [3:0]  bm;
        @(negedge ACLK);
        CSn = cs; RASn = ras; CASn = cas; WEn = wen; A = a; D = d;
        k   = edge_cnt + 1;
        err = 0;
        key = m_row * (1 << COL_BITS) + int'(a[COL_BITS-1:0]);
        // Read sees the word as it stood before any commit on this edge;
        // the consumer samples it at edge k+CAS_LAT, i.e. it is observable
        // after edge k+CAS_LAT-1.
        if (!cs && ras && !cas && wen == 4'hF && m_row_valid) begin
            e.known = ref_bytes.exists(key) && ref_bytes[key] == 4'hF;
            e.data  = e.known ? ref_mem[key] : 32'h0;
            e.due   = k + CAS_LAT - 1;
            exp_q.push_back(e);
        end
        if (m_pend) begin
            w  = ref_mem.exists(m_pend_key) ? ref_mem[m_pend_key] : 32'h0;
            bm = ref_bytes.exists(m_pend_key) ? ref_bytes[m_pend_key] : 4'h0;
            for (int b = 0; b < 4; b++) begin
                if (!m_pend_wen[b]) begin
                    w[8*b +: 8] = d[8*b +: 8];
                    bm[b]       = 1'b1;
                end
            end
            ref_mem[m_pend_key]   = w;
            ref_bytes[m_pend_key] = bm;
            m_pend = 0;
        end
        if (!cs) begin
            if (!ras && !cas) begin
                err = 1;
            end else if (!ras) begin
                if (wen == 4'h0) m_last_pre = k;
                else if (wen == 4'hF) begin
                    if (k - m_last_pre < T_RP) err = 1;
                    else begin
                        m_row       = int'(a[ROW_BITS-1:0]);
                        m_row_valid = 1;
                    end
                end else err = 1;
            end else if (!cas) begin
                if (!m_row_valid) err = 1;
                else if (wen != 4'hF) begin
                    m_pend     = 1;
                    m_pend_key = key;
                    m_pend_wen = wen;
                end
            end
        end
        if (err) exp_err[k] = 1;
    endtask

    task automatic nop(input logic [31:0] d);
        issue(1'b1, 1'($urandom), 1'($urandom), 4'($urandom), 11'($urandom), d);
    endtask
    task automatic idle(input int n);
        repeat (n) nop($urandom);
    endtask
    task automatic rd(input int col);
        issue(1'b0, 1'b1, 1'b0, 4'hF, 11'(col), $urandom);
    endtask
    task automatic wr(input int col, input logic [3:0] wen);
        issue(1'b0, 1'b1, 1'b0, wen, 11'(col), $urandom);
    endtask
    task automatic act(input int row);
        issue(1'b0, 1'b0, 1'b1, 4'hF, 11'(row), $urandom);
    endtask
    task automatic pre();
        issue(1'b0, 1'b0, 1'b1, 4'h0, 11'($urandom), $urandom);
    endtask

    task automatic do_reset();
        @(negedge ACLK);
        #2;
        rst = 1'b1; CSn = 1'b1;
        exp_q.delete();
        m_row_valid = 0; m_pend = 0; m_last_pre = -100;
        last_q = '0; last_known = 1;
        #1;
        check("reset_Q", Q, 32'h0);
        check("reset_VALID", {31'b0, VALID}, 32'h0);
        check("reset_ERR", {31'b0, ERR}, 32'h0);
        @(negedge ACLK);
        #2;
        rst = 1'b0;
    endtask

    // Monitor: ERR every cycle, VALID against the read queue, Q hold otherwise.
    always @(negedge ACLK) begin
        rd_t e;
        bit  ee;
        if (!rst) begin
            ee = exp_err.exists(edge_cnt) ? 1'b1 : 1'b0;
            check("err_pulse", {31'b0, ERR}, {31'b0, ee});
            if (VALID === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", {31'b0, VALID}, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("read_latency", 32'(edge_cnt), 32'(e.due));
                    if (e.known) check("read_data", Q, e.data);
                    last_q     = e.data;
                    last_known = e.known;
                end
            end else begin
                check("valid_level", {31'b0, VALID}, 32'h0);
                if (exp_q.size() > 0 && exp_q[0].due <= edge_cnt) begin
                    e = exp_q.pop_front();
                    check("missing_valid", 32'(edge_cnt), 32'(e.due + 1000000));
                end
                if (last_known) check("q_hold", Q, last_q);
            end
        end
    end

    initial begin
        int r;
        int col;
        #1;
        check("reset_Q", Q, 32'h0);
        check("reset_VALID", {31'b0, VALID}, 32'h0);
        @(negedge ACLK);
        #2;
        rst = 1'b0;

        // No open row: RD and WR rejected; both strobes low rejected.
        rd(4);
        wr(4, 4'h0);
        issue(1'b0, 1'b0, 1'b0, 4'hF, 11'h004, 32'h0);
        idle(3);

        // Basic write then read on row 0x012.
        act(12'h012);
        wr(4, 4'h0);
        nop(32'hDEADBEEF);
        rd(4);
        idle(CAS_LAT + 2);

        // Byte enables: 0x11223344 merged with 0xAABBCCDD under WEn=1010.
        wr(5, 4'h0);
        nop(32'h11223344);
        wr(5, 4'b1010);
        nop(32'hAABBCCDD);
        rd(5);
        issue(1'b0, 1'b0, 1'b0, 4'h0, 11'h005, 32'hFFFFFFFF);
        rd(5);
        idle(CAS_LAT + 2);

        // Back-to-back writes (each data phase carries the next WR), then back-to-back reads.
        wr(10, 4'h0);
        issue(1'b0, 1'b1, 1'b0, 4'h0, 11'd11, 32'h0000000A);
        issue(1'b0, 1'b1, 1'b0, 4'h0, 11'd12, 32'h0000000B);
        nop(32'h0000000C);
        rd(10); rd(11); rd(12);
        idle(CAS_LAT + 2);

        // RD on the same edge as a commit returns the old word.
        wr(4, 4'h0);
        issue(1'b0, 1'b1, 1'b0, 4'hF, 11'd4, 32'h12345678);
        rd(4);
        idle(CAS_LAT + 2);

        // Malformed ACT byte-enable pattern.
        issue(1'b0, 1'b0, 1'b1, 4'h5, 11'h034, 32'h0);

        // tRP: ACT one cycle after PRE rejected, two cycles after accepted.
        pre();
        act(12'h034);
        rd(4);
        pre();
        nop($urandom);
        act(12'h034);
        wr(1, 4'h0);
        nop(32'hCAFEF00D);
        rd(1);
        idle(CAS_LAT + 2);

        // Reset while a read is in flight.
        rd(1);
        nop($urandom);
        do_reset();
        rd(1);
        idle(CAS_LAT + 2);

        // Preload rows 0..3, columns 0..7, then random traffic.
        for (int row = 0; row < 4; row++) begin
            act(row);
            for (int c = 0; c < 8; c++) begin
                wr(c, 4'h0);
                nop($urandom);
            end
        end
        for (int i = 0; i < 800; i++) begin
            r   = $urandom_range(0, 99);
            col = $urandom_range(0, 7) | ($urandom_range(0, 31) << COL_BITS);
            if (r < 25)      nop($urandom);
            else if (r < 50) rd(col);
            else if (r < 72) wr(col, 4'($urandom_range(0, 14)));
            else if (r < 82) act($urandom_range(0, 3) | ($urandom_range(0, 7) << ROW_BITS));
            else if (r < 90) pre();
            else if (r < 95) issue(1'b0, 1'b0, 1'b0, 4'($urandom), 11'(col), $urandom);
            else             issue(1'b0, 1'b0, 1'b1, 4'($urandom_range(1, 14)), 11'(col), $urandom);
        end
        idle(CAS_LAT + 4);
        check("reads_drained", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dram_responder.md
DRAM_RESPONDER -- requirements
Module: dram_responder

Interface
REQ-001 SHALL have parameters: ROW_BITS, default 11, row address width; COL_BITS, default 10, column address width (≤11); CAS_LAT, default 5, CAS-read-to-VALID latency in cycles (1..7); T_RP, default 1, minimum cycles from PRE to ACT.
REQ-002 SHALL have ports: ACLK  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: CSn  in  1  chip select, active-low.
REQ-005 SHALL have ports: RASn  in  1  row strobe, active-low.
REQ-006 SHALL have ports: CASn  in  1  column strobe, active-low.
REQ-007 SHALL have ports: WEn  in  4  per-byte write enables, active-low; WEn[i] covers D[8i+7:8i].
REQ-008 SHALL have ports: A  in  11  multiplexed row/column address.
REQ-009 SHALL have ports: D  in  32  write data.
REQ-010 SHALL have ports: Q  out  32  read data.
REQ-011 SHALL have ports: VALID  out  1  one-cycle pulse marking Q valid.
REQ-012 SHALL have ports: ERR  out  1  one-cycle pulse flagging an illegal command.

Function
REQ-013 SHALL hold a storage array of 2^(ROW_BITS+COL_BITS) 32-bit words, word index {row_reg, col}; array contents are not reset.
REQ-014 SHALL decode one command per rising edge, only when CSn=0; CSn=1 is NOP.
REQ-015 SHALL decode PRE as RASn=0, CASn=1, WEn=4'h0: start T_RP counter; row_reg and row_valid unchanged.
REQ-016 SHALL decode ACT as RASn=0, CASn=1, WEn=4'hF: row_reg <= A[ROW_BITS-1:0], row_valid <= 1.
REQ-017 SHALL decode RD as RASn=1, CASn=0, WEn=4'hF: read word {row_reg, A[COL_BITS-1:0]} at this edge into a CAS_LAT-deep pipeline.
REQ-018 SHALL decode WR as RASn=1, CASn=0, WEn≠4'hF: latch column and WEn; on the next rising edge sample D and commit bytes whose WEn bit is 0; other bytes unchanged.
REQ-019 SHALL drive Q and VALID=1 exactly CAS_LAT cycles after the RD edge; VALID=0 otherwise; Q holds its last value while VALID=0.
REQ-020 SHALL accept back-to-back RD on consecutive cycles, producing consecutive VALID pulses in order.
REQ-021 SHALL complete a pending WR data-phase commit even if the data-phase cycle carries NOP, CSn=1, or another command.
REQ-022 SHALL give the pre-commit (old) word when RD hits an address in the same edge as its WR commit.
REQ-023 SHALL let a second WR in the data-phase cycle of a first WR commit in its own following cycle; both commits occur.
REQ-024 SHALL raise ERR for one cycle and otherwise ignore the command when: RASn=0 and CASn=0; RD/WR with row_valid=0; ACT fewer than T_RP cycles after PRE; RASn=0, CASn=1, WEn not 4'h0 or 4'hF.
REQ-025 SHALL ignore A, D and WEn when the cycle is a NOP.

Reset
REQ-026 SHALL on rst=1 force immediately: Q=0, VALID=0, ERR=0, row_reg=0, row_valid=0, read pipeline empty, pending write dropped, T_RP counter expired.
REQ-027 SHALL produce no VALID after reset for any RD issued before reset (reset mid-read discards in-flight reads).

Verification
REQ-028 SHALL cover: ACT row 0x012, WR col 0x004 WEn=0 D=0xDEADBEEF next cycle, RD col 0x004 -> VALID exactly 5 cycles after RD, Q=0xDEADBEEF.
REQ-029 SHALL cover: preload 0x11223344, WR WEn=4'b1010 D=0xAABBCCDD -> subsequent RD returns 0x11BB33DD.
REQ-030 SHALL cover: RD at cycles n, n+1, n+2 to words 0xA, 0xB, 0xC -> VALID high at n+5..n+7, Q=0xA,0xB,0xC in order.
REQ-031 SHALL cover: RD after reset with no ACT -> ERR=1 one cycle, no VALID; RASn=CASn=0 -> ERR=1, array unchanged.
REQ-032 SHALL cover: PRE then ACT on next cycle with T_RP=2 -> ERR=1, row_reg unchanged; ACT two cycles after PRE -> accepted, no ERR.
REQ-033 SHALL cover: RD then rst asserted 2 cycles later for 1 cycle -> Q=0, VALID never asserts for that RD.
